par_shift_tx: RTL and testbench

PAR_SHIFT_TX -- requirements
Module: par_shift_tx

---
 rtl/par_shift_pkg.sv | 13 +
 rtl/par_shift_tx_bit_cnt.sv | 36 +++
 rtl/par_shift_tx.sv | 93 +++++++++
 tb/tb_par_shift_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/par_shift_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package par_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/par_shift_tx_bit_cnt.sv
// Frame bit counter: cleared on load, advanced once per emitted bit.
module bit_cnt #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CntW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            last
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/par_shift_tx.sv
// Parallel-to-serial transmitter with selectable bit order and a done pulse per frame.
module par_shift_tx
  import par_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic [CntW-1:0]  cnt_q;

  bit_cnt #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt_q),
    .last  (cnt_last)
  );

  // Ready is gated by rst so nothing is offered while reset is held.
  assign load_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dir_d   = dir_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          sh_d    = din;
          dir_d   = dir;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d    = (dir_q == DIR_LSB_FIRST) ? (sh_q >> 1) : (sh_q << 1);
        cnt_inc = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dir_q   <= dir_d;
    end
  end

  assign sout_valid = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign sout       = sout_valid &&
                      ((dir_q == DIR_LSB_FIRST) ? sh_q[0] : sh_q[WIDTH-1]);

  // The counter never runs past the last bit index while a frame is shifting.
  assert property (@(posedge clk) disable iff (rst)
                   (state_q == SHIFT) |-> (cnt_q <= CntW'(WIDTH - 1)));

endmodule

// File: tb/tb_par_shift_tx.sv
// Bench for par_shift_tx: frame-level reference model plus directed literal scenarios.
module tb_par_shift_tx;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_ready, sout, sout_valid, done;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  par_shift_tx #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: phase 0 = idle, 1..W = emitting bit phase-1, W+1 = done cycle.
  int          phase = 0;
  logic [31:0] mbits = '0;

  function automatic logic [31:0] frame_bits(input logic [W-1:0] d, input logic r);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < W; k++) begin
      b[k] = r ? d[k] : d[W-1-k];
    end
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (load_valid) begin
        phase <= 1;
        mbits <= frame_bits(din, dir);
      end
    end else if (phase == W + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic ev;
      int   idx;
      ev  = (phase >= 1) && (phase <= W);
      idx = ev ? phase - 1 : 0;
      chk("m_ready", {31'd0, load_ready}, {31'd0, (phase == 0) && !rst});
      chk("m_valid", {31'd0, sout_valid}, {31'd0, ev});
      chk("m_sout", {31'd0, sout}, {31'd0, ev && mbits[idx]});
      chk("m_done", {31'd0, done}, {31'd0, phase == W + 1});
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (load_ready) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // e[W-1] is the first expected serial bit.
  task automatic frame(input logic [W-1:0] d, input logic r, input logic [W-1:0] e,
                       input bit noisy);
    wait_ready();
    #1;
    load_valid = 1'b1;
    din        = d;
    dir        = r;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c <= W) begin
        chk($sformatf("bit%0d", c), {31'd0, sout}, {31'd0, e[W-c]});
        chk("valid_hi", {31'd0, sout_valid}, 32'd1);
        chk("ready_lo", {31'd0, load_ready}, 32'd0);
      end else if (c == W + 1) begin
        chk("done_hi", {31'd0, done}, 32'd1);
        chk("valid_lo", {31'd0, sout_valid}, 32'd0);
      end else begin
        chk("ready_hi", {31'd0, load_ready}, 32'd1);
      end
      #1;
      if (c == 1) begin
        din        = noisy ? 5'b00011 : ~d;
        dir        = ~r;
        load_valid = noisy;
      end
      if (c == W + 1) load_valid = 1'b0;
    end
  endtask

  initial begin
    int second;

    // Power-on reset, asserted between edges.
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_sout", {31'd0, sout}, 32'd0);
    chk("rst_valid", {31'd0, sout_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, load_ready}, 32'd1);

    frame(5'b10110, 1'b0, 5'b10110, 1'b0);
    frame(5'b10110, 1'b1, 5'b01101, 1'b0);
    frame(5'b11100, 1'b0, 5'b11100, 1'b1);
    @(negedge clk);
    chk("no_extra_accept", {31'd0, sout_valid}, 32'd0);

    // Reset in the middle of a frame: outputs drop at once, no done pulse follows.
    wait_ready();
    #1;
    load_valid = 1'b1;
    din        = 5'b10101;
    dir        = 1'b0;
    @(negedge clk);
    chk("ab_bit1", {31'd0, sout}, 32'd1);
    #1 load_valid = 1'b0;
    @(negedge clk);
    chk("ab_bit2", {31'd0, sout}, 32'd0);
    @(negedge clk);
    chk("ab_bit3", {31'd0, sout}, 32'd1);
    chk("ab_valid_before", {31'd0, sout_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ab_sout", {31'd0, sout}, 32'd0);
    chk("ab_valid", {31'd0, sout_valid}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_ready", {31'd0, load_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("ab_no_done_rst", {31'd0, done}, 32'd0);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ab_no_done", {31'd0, done}, 32'd0);
      if (i == 0) chk("ab_ready_after", {31'd0, load_ready}, 32'd1);
    end
    frame(5'b00001, 1'b1, 5'b10000, 1'b0);

    // Reset during the done cycle kills the pulse immediately.
    wait_ready();
    #1;
    load_valid = 1'b1;
    din        = 5'b11111;
    dir        = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1) #1 load_valid = 1'b0;
    end
    chk("dn_done_hi", {31'd0, done}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("dn_done_rst", {31'd0, done}, 32'd0);
    chk("dn_ready_rst", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("dn_ready_after", {31'd0, load_ready}, 32'd1);

    // Back-to-back loads with load_valid held high.
    wait_ready();
    #1;
    load_valid = 1'b1;
    din        = 5'b11111;
    dir        = 1'b0;
    second     = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (load_ready) begin
        second = i;
        break;
      end
      #1 din = 5'b00000;
    end
    chk("accept_gap", second, 32'd7);
    @(negedge clk);
    chk("b2b_valid", {31'd0, sout_valid}, 32'd1);
    chk("b2b_sout", {31'd0, sout}, 32'd0);
    #1 load_valid = 1'b0;

    // Randomized traffic, including occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 40) == 0) rst = 1'b1;
      load_valid = ($urandom_range(0, 3) != 0);
      din        = W'($urandom);
      dir        = 1'($urandom);
    end
    @(negedge clk);
    #1;
    rst        = 1'b0;
    load_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
